bcd2bin: RTL and testbench
==========================

# bcd2bin

Iterative BCD-to-binary converter using reverse double dabble: shift right, then subtract 3 from any digit ≥ 8. It is the inverse path of the stopwatch's binary-to-BCD display conversion. It takes packed BCD values, such as digit-entry presets or lap targets, and returns binary for the counter/compare logic. Valid/ready handshakes are used on both sides, with one conversion in flight at a time.

## Interface
- DIGITS, 3, number of packed BCD input digits (≥ 1)
- BIN_W, 10, output width; must satisfy 2^BIN_W > 10^DIGITS − 1 (10 for 3 digits); equals the iteration count
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- i_valid  in  1  input word valid
- i_ready  out  1  converter idle, can accept
- i_bcd  in  4*DIGITS  packed BCD, digit 0 in [3:0]
- o_valid  out  1  result valid
- o_ready  in  1  downstream accepts result
- o_bin  out  BIN_W  binary result
- o_err  out  1  input contained a nibble > 9 (see Configuration)

## Operation
- FSM states:
  - IDLE: i_ready=1. On i_valid&&i_ready, load the BCD register ← i_bcd, binary register ← 0, cnt ← 0, then go to SHIFT.
  - SHIFT: i_ready=0. Each cycle, shift {bcd, bin} right by 1 (bcd LSB enters bin MSB). Then, for every digit of the shifted bcd, if digit ≥ 8, digit ← digit − 3 (4-bit, no carry between digits). cnt increments each cycle. On the step where cnt == BIN_W−1, go to DONE and register o_bin ← shifted bin.
  - DONE: o_valid=1, o_bin/o_err held stable. On o_ready, go to IDLE.
- o_valid is 1 only in DONE. i_ready is 1 only in IDLE; it is combinational from state and is never high in DONE, even if o_ready is high.
- Counter cnt width: $clog2(BIN_W).
- The BCD register is all-zero after BIN_W steps for valid input; the design does not check this.
- Reset: rst_n low on any edge forces IDLE, cnt=0, o_bin=0, o_err=0, o_valid=0, discarding any conversion in progress. i_ready=1 from the first edge after reset.
- Input changes while not in IDLE are ignored.

## Timing
- The accepting edge is E0. SHIFT steps occur on E1..E_BIN_W. o_valid is visible after edge E_BIN_W, which is latency BIN_W cycles (10 at default).
- The handshake edge returns the FSM to IDLE, and the next accept can occur one edge later.
  - Minimum period is BIN_W+2 cycles (12 at default).
- Output backpressure is unlimited. o_bin and o_err must not change while o_valid=1 and o_ready=0.

## Configuration
- Macro: BCD2BIN_CHECK_EN.
- Defined:
  - At accept, register a flag set if any input nibble > 9.
  - In DONE, o_err equals that flag, and o_bin is forced to 0 when o_err=1.
  - Latency and handshake are unchanged.
- Undefined: o_err is tied to 0, no check logic is built, and o_bin for an invalid input is unspecified (algorithm output).

## Structure
- Package bcd_pkg holds:
  - the state enum (IDLE, SHIFT, DONE);
  - default DIGITS/BIN_W localparams;
  - a function for the minimum BIN_W given DIGITS, used in an elaboration-time assertion.
- Sub-module bcd2bin_step: purely combinational single iteration (shift plus per-digit −3 correction), parameterised by DIGITS/BIN_W. The top level holds the FSM, counter and registers.

## Test plan
- Reset released, i_bcd=12'h255 pulsed valid, o_ready=1 → o_valid rises 10 cycles after accept with o_bin=255, o_err=0; i_ready low throughout.
- Boundaries 12'h000 and 12'h999 → o_bin=0 and o_bin=999 respectively.
- 12'h407 accepted, o_ready held low 20 cycles → o_valid stays 1, o_bin=407 stable; i_ready=0; a new i_valid during the hold is ignored.
- Back-to-back inputs 12'h001, 12'h010, 12'h100 with i_valid constantly high and o_ready=1 → results 1, 10, 100; accepts spaced exactly 12 cycles apart.
- rst_n low for 1 cycle at step 5 of the conversion of 12'h321 → o_valid never rises for it; next input 12'h042 returns 42.
- With BCD2BIN_CHECK_EN defined, i_bcd=12'h1A3 → o_err=1, o_bin=0 at latency 10. Without the macro, o_err=0.

Source files
------------

// File: rtl/bcd2bin_pkg.sv
// Shared types and sizing helpers for the BCD-to-binary converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DIGITS_DEF = 3;
  localparam int BIN_W_DEF  = 10;

  // Smallest width w with 2^w > 10^digits - 1.
  function automatic int min_bin_w(input int digits);
    longint lim;
    int     r;
    lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    lim = lim - 1;
    r = 63;
    for (int w = 62; w >= 1; w--) begin
      if ((longint'(1) << w) > lim) r = w;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd2bin_if.sv
// Valid/ready bundle between a producer of packed BCD and the converter.
interface bcd2bin_if
  import bcd_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int BIN_W  = BIN_W_DEF
) ();

  logic                  i_valid;
  logic                  i_ready;
  logic [4*DIGITS-1:0]   i_bcd;
  logic                  o_valid;
  logic                  o_ready;
  logic [BIN_W-1:0]      o_bin;
  logic                  o_err;

  modport master (
    output i_valid, i_bcd, o_ready,
    input  i_ready, o_valid, o_bin, o_err
  );

  modport slave (
    input  i_valid, i_bcd, o_ready,
    output i_ready, o_valid, o_bin, o_err
  );

endinterface

// File: rtl/bcd2bin_step.sv
// One reverse double-dabble iteration: shift {bcd,bin} right,
// then take 3 off every BCD digit that landed at 8 or above.
module bcd2bin_step #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic [4*DIGITS-1:0] bcd_i,
  input  logic [BIN_W-1:0]    bin_i,
  output logic [4*DIGITS-1:0] bcd_o,
  output logic [BIN_W-1:0]    bin_o
);

  logic [4*DIGITS-1:0] bcd_sh;

  always_comb begin
    {bcd_sh, bin_o} = {bcd_i, bin_i} >> 1;
    bcd_o = bcd_sh;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_sh[4*d+3]) begin
        bcd_o[4*d +: 4] = bcd_sh[4*d +: 4] - 4'd3;
      end
    end
  end

endmodule

// File: rtl/bcd2bin.sv
// Iterative BCD-to-binary converter, one conversion in flight.
// Define BCD2BIN_CHECK_EN to flag and zero results of non-decimal input.
module bcd2bin
  import bcd_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int BIN_W  = BIN_W_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  bcd2bin_if.slave  bus
);

  localparam int BW    = 4 * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  if (DIGITS < 1 || BIN_W < min_bin_w(DIGITS)) begin : g_bad_cfg
    $error("bcd2bin: BIN_W too small for DIGITS");
  end

  state_e             state_q, state_d;
  logic [BW-1:0]      bcd_q, bcd_d, bcd_s;
  logic [BIN_W-1:0]   bin_q, bin_d, bin_s;
  logic [BIN_W-1:0]   obin_q, obin_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last;
  logic               kill;

  bcd2bin_step #(
    .DIGITS (DIGITS),
    .BIN_W  (BIN_W)
  ) u_step (
    .bcd_i (bcd_q),
    .bin_i (bin_q),
    .bcd_o (bcd_s),
    .bin_o (bin_s)
  );

  assign last = (cnt_q == CNT_W'(BIN_W - 1));

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    obin_d  = obin_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          bcd_d   = bus.i_bcd;
          bin_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = bcd_s;
        bin_d = bin_s;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          obin_d  = kill ? '0 : bin_s;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.o_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      bin_q   <= '0;
      obin_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      obin_q  <= obin_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef BCD2BIN_CHECK_EN
  logic in_bad;
  logic flag_q;
  logic err_q;

  always_comb begin
    in_bad = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (bus.i_bcd[4*d +: 4] > 4'd9) in_bad = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flag_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (state_q == IDLE && bus.i_valid) flag_q <= in_bad;
      if (state_q == SHIFT && last) err_q <= flag_q;
    end
  end

  assign kill      = flag_q;
  assign bus.o_err = err_q;
`else
  assign kill      = 1'b0;
  assign bus.o_err = 1'b0;
`endif

  assign bus.i_ready = (state_q == IDLE);
  assign bus.o_valid = (state_q == DONE);
  assign bus.o_bin   = obin_q;

endmodule

// File: tb/tb_bcd2bin.sv
// Self-checking bench for bcd2bin: directed table, corner
// sequences and random traffic against a decimal model.
module tb_bcd2bin;

  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;
  localparam int LAT    = BIN_W;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   cyc;

  bcd2bin_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

  bcd2bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] bcd;
    int          hold;
    bit          inj;
    int          exp;
    bit          bad_in;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic int model_val(input logic [11:0] b);
    int v;
    v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
    return v;
  endfunction

  function automatic bit model_bad(input logic [11:0] b);
    bit r;
    r = 1'b0;
    for (int i = 0; i < DIGITS; i++) if (b[4*i +: 4] > 4'd9) r = 1'b1;
    return r;
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while (!bus.i_ready && n < 40) begin
      tick();
      n++;
    end
    if (!bus.i_ready) chk("idle_timeout", 0, 1);
  endtask

  task automatic xfer(input logic [11:0] bcd, input int hold,
                      input bit inj, input int exp, input bit bad_in);
    int lat;
    bit rdy_seen;
    logic [BIN_W-1:0] held;
    logic held_err;
    wait_idle();
    bus.i_valid = 1'b1;
    bus.i_bcd   = bcd;
    bus.o_ready = 1'b0;
    tick();
    bus.i_valid = 1'b0;
    lat = 0;
    rdy_seen = 1'b0;
    while (!bus.o_valid && lat < 40) begin
      if (bus.i_ready) rdy_seen = 1'b1;
      tick();
      lat++;
    end
    chk("latency", lat, LAT);
    chk("i_ready_busy", int'(rdy_seen), 0);
`ifdef BCD2BIN_CHECK_EN
    chk("o_err", int'(bus.o_err), int'(bad_in));
    chk("o_bin", int'(bus.o_bin), bad_in ? 0 : exp);
`else
    chk("o_err", int'(bus.o_err), 0);
    if (!bad_in) chk("o_bin", int'(bus.o_bin), exp);
`endif
    held = bus.o_bin;
    held_err = bus.o_err;
    for (int h = 0; h < hold; h++) begin
      if (inj && h == 5) begin
        bus.i_valid = 1'b1;
        bus.i_bcd   = 12'h999;
      end
      tick();
      chk("hold_valid", int'(bus.o_valid), 1);
      chk("hold_bin", int'(bus.o_bin), int'(held));
      chk("hold_err", int'(bus.o_err), int'(held_err));
      chk("hold_i_ready", int'(bus.i_ready), 0);
    end
    bus.i_valid = 1'b0;
    bus.o_ready = 1'b1;
    tick();
    bus.o_ready = 1'b0;
    chk("post_valid", int'(bus.o_valid), 0);
    chk("post_i_ready", int'(bus.i_ready), 1);
  endtask

  vec_t tbl[6];
  logic [11:0] seq[3];
  int   seq_exp[3];
  int   acc_t[3];
  int   na;
  int   nr;
  int   n;
  int   seen;
  logic [11:0] rb;

  initial begin
    total = 0;
    bad = 0;
    cyc = 0;
    rst_n = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_bcd = '0;
    bus.o_ready = 1'b0;

    tbl[0] = '{12'h255, 0,  1'b0, 255, 1'b0};
    tbl[1] = '{12'h000, 0,  1'b0, 0,   1'b0};
    tbl[2] = '{12'h999, 2,  1'b0, 999, 1'b0};
    tbl[3] = '{12'h407, 20, 1'b1, 407, 1'b0};
    tbl[4] = '{12'h1A3, 0,  1'b0, 0,   1'b1};
    tbl[5] = '{12'h090, 1,  1'b0, 90,  1'b0};

    tick();
    tick();
    chk("rst_o_valid", int'(bus.o_valid), 0);
    chk("rst_o_bin", int'(bus.o_bin), 0);
    chk("rst_o_err", int'(bus.o_err), 0);
    chk("rst_i_ready", int'(bus.i_ready), 1);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      xfer(tbl[i].bcd, tbl[i].hold, tbl[i].inj, tbl[i].exp, tbl[i].bad_in);
    end

    // back-to-back with i_valid held high
    seq[0] = 12'h001; seq_exp[0] = 1;
    seq[1] = 12'h010; seq_exp[1] = 10;
    seq[2] = 12'h100; seq_exp[2] = 100;
    na = 0;
    nr = 0;
    n = 0;
    bus.o_ready = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_bcd = seq[0];
    while (nr < 3 && n < 80) begin
      if (bus.o_valid) begin
        chk("b2b_bin", int'(bus.o_bin), seq_exp[nr]);
        nr++;
      end
      if (bus.i_ready && na < 3) begin
        acc_t[na] = cyc;
        na++;
      end
      if (nr == 3) bus.i_valid = 1'b0;
      tick();
      n++;
      if (na < 3) bus.i_bcd = seq[na];
    end
    bus.i_valid = 1'b0;
    bus.o_ready = 1'b0;
    chk("b2b_results", nr, 3);
    if (na == 3) begin
      chk("b2b_gap1", acc_t[1] - acc_t[0], BIN_W + 2);
      chk("b2b_gap2", acc_t[2] - acc_t[1], BIN_W + 2);
    end else begin
      chk("b2b_accepts", na, 3);
    end
    tick();

    // reset in the middle of a conversion
    wait_idle();
    bus.i_valid = 1'b1;
    bus.i_bcd = 12'h321;
    tick();
    bus.i_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_i_ready", int'(bus.i_ready), 1);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.o_valid) seen = 1;
      tick();
    end
    chk("mid_rst_no_valid", seen, 0);
    xfer(12'h042, 0, 1'b0, 42, 1'b0);

    // random traffic against the decimal model
    for (int k = 0; k < 40; k++) begin
      rb = '0;
      for (int d = 0; d < DIGITS; d++) begin
        if ($urandom_range(0, 5) == 0) rb[4*d +: 4] = 4'($urandom_range(0, 15));
        else rb[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      xfer(rb, $urandom_range(0, 3), 1'b0, model_val(rb), model_bad(rb));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
